// File: rtl/keypad_emulator.sv
// Key-side model of a 4x3 matrix keypad: accepts press requests and answers the
// scanner's row drive on the column lines, with press/release bounce, hold and gap.
module keypad_emulator #(
    parameter int HOLD_CYCLES   = 1000000,
    parameter int BOUNCE_CYCLES = 50000,
    parameter int BOUNCE_PERIOD = 5000,
    parameter int GAP_CYCLES    = 1000000,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             key_ready,
    input  logic [3:0]       keyboard_rows,
    output logic [2:0]       keyboard_cols,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_BOUNCE,
        HOLD,
        REL_BOUNCE,
        GAP
    } state_t;

    localparam bit HAS_BOUNCE = (BOUNCE_CYCLES > 0);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(BOUNCE_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

    state_t           state, state_next;
    logic             contact, contact_next;
    logic [1:0]       key_row, row_next;
    logic [1:0]       key_col, col_next;
    logic [CNT_W-1:0] phase_cnt, phase_next;
    logic [CNT_W-1:0] period_cnt, period_next;
    logic             done_next, err_next;

    logic             code_valid;
    logic [1:0]       code_row, code_col;

    always_comb begin
        code_valid = 1'b1;
        code_row   = 2'd0;
        code_col   = 2'd0;
        case (key_code)
            4'd1:    begin code_row = 2'd0; code_col = 2'd0; end
            4'd2:    begin code_row = 2'd0; code_col = 2'd1; end
            4'd3:    begin code_row = 2'd0; code_col = 2'd2; end
            4'd4:    begin code_row = 2'd1; code_col = 2'd0; end
            4'd5:    begin code_row = 2'd1; code_col = 2'd1; end
            4'd6:    begin code_row = 2'd1; code_col = 2'd2; end
            4'd7:    begin code_row = 2'd2; code_col = 2'd0; end
            4'd8:    begin code_row = 2'd2; code_col = 2'd1; end
            4'd9:    begin code_row = 2'd2; code_col = 2'd2; end
            4'd10:   begin code_row = 2'd3; code_col = 2'd0; end
            4'd0:    begin code_row = 2'd3; code_col = 2'd1; end
            4'd11:   begin code_row = 2'd3; code_col = 2'd2; end
            default: code_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            contact    <= 1'b0;
            key_row    <= 2'd0;
            key_col    <= 2'd0;
            phase_cnt  <= '0;
            period_cnt <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_next;
            contact    <= contact_next;
            key_row    <= row_next;
            key_col    <= col_next;
            phase_cnt  <= phase_next;
            period_cnt <= period_next;
            done       <= done_next;
            err        <= err_next;
        end
    end

    // Both counters restart from zero whenever the state changes.
    always_comb begin
        state_next   = state;
        contact_next = contact;
        row_next     = key_row;
        col_next     = key_col;
        phase_next   = phase_cnt + CNT_W'(1);
        period_next  = period_cnt + CNT_W'(1);
        done_next    = 1'b0;
        err_next     = 1'b0;
        case (state)
            IDLE: begin
                phase_next  = '0;
                period_next = '0;
                if (key_valid) begin
                    if (code_valid) begin
                        row_next     = code_row;
                        col_next     = code_col;
                        contact_next = 1'b1;
                        state_next   = HAS_BOUNCE ? PRESS_BOUNCE : HOLD;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            PRESS_BOUNCE, REL_BOUNCE: begin
                if (period_cnt == PERIOD_LAST) begin
                    contact_next = ~contact;
                    period_next  = '0;
                end
                if (phase_cnt == BOUNCE_LAST) begin
                    phase_next  = '0;
                    period_next = '0;
                    if (state == PRESS_BOUNCE) begin
                        contact_next = 1'b1;
                        state_next   = HOLD;
                    end else begin
                        contact_next = 1'b0;
                        state_next   = GAP;
                    end
                end
            end
            HOLD: begin
                if (phase_cnt == HOLD_LAST) begin
                    phase_next   = '0;
                    period_next  = '0;
                    contact_next = 1'b0;
                    state_next   = HAS_BOUNCE ? REL_BOUNCE : GAP;
                end
            end
            GAP: begin
                if (phase_cnt == GAP_LAST) begin
                    phase_next  = '0;
                    period_next = '0;
                    done_next   = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                contact_next = 1'b0;
            end
        endcase
    end

    // Combinational on purpose: the scanner moves to a new row every cycle.
    always_comb begin
        keyboard_cols = {key_col == 2'd2, key_col == 2'd1, key_col == 2'd0}
                        & {3{contact & keyboard_rows[key_row]}};
    end

    assign key_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized self-checking bench for keypad_emulator, one instance without bounce
// and one with bounce, compared against a cycle-offset model of a press sequence.
module tb_keypad_emulator;

    localparam int H  = 8;
    localparam int P  = 2;
    localparam int G  = 6;
    localparam int BB = 4;

    localparam int KROW [12] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3};
    localparam int KCOL [12] = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 2};

    logic       clk;
    logic       rstn;
    logic [3:0] rows;
    logic [3:0] key_code;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic [2:0] cols_a, cols_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;
    logic       err_a, err_b;

    int total  = 0;
    int passed = 0;

    keypad_emulator #(
        .HOLD_CYCLES(H), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(P), .GAP_CYCLES(G), .CNT_W(32)
    ) dut_a (
        .clk(clk), .rstn(rstn), .key_valid(valid_a), .key_code(key_code),
        .key_ready(ready_a), .keyboard_rows(rows), .keyboard_cols(cols_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    keypad_emulator #(
        .HOLD_CYCLES(H), .BOUNCE_CYCLES(BB), .BOUNCE_PERIOD(P), .GAP_CYCLES(G), .CNT_W(32)
    ) dut_b (
        .clk(clk), .rstn(rstn), .key_valid(valid_b), .key_code(key_code),
        .key_ready(ready_b), .keyboard_rows(rows), .keyboard_cols(cols_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offset (in cycles after acceptance) of the done cycle.
    function automatic int done_index(int b);
        return 1 + 2 * b + H + G;
    endfunction

    // Contact level k cycles after acceptance: press bounce, hold, release bounce, gap.
    function automatic bit exp_contact(int k, int b);
        int t;
        if (k < 1) return 1'b0;
        t = k - 1;
        if (t < b) return ((t / P) % 2) == 0;
        t = t - b;
        if (t < H) return 1'b1;
        t = t - H;
        if (t < b) return ((t / P) % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [2:0] exp_cols(int k, int b, logic [3:0] code, logic [3:0] r);
        int idx;
        logic [2:0] c;
        idx = int'(code);
        c = 3'b000;
        if (idx <= 11 && exp_contact(k, b) && r[KROW[idx]]) c = 3'b001 << KCOL[idx];
        return c;
    endfunction

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            rstn = 1'b0; valid_a = 1'b1; valid_b = 1'b1; key_code = 4'd5;
            rows = 4'($urandom_range(0, 15));
            #4;
            total++; if (cols_a !== 3'b000) $display("[TB] FAIL reset_cols_a k=%0d got=%b exp=000", k, cols_a); else passed++;
            total++; if (cols_b !== 3'b000) $display("[TB] FAIL reset_cols_b k=%0d got=%b exp=000", k, cols_b); else passed++;
            total++; if (ready_a !== 1'b1 || ready_b !== 1'b1) $display("[TB] FAIL reset_ready k=%0d got=%b%b exp=11", k, ready_a, ready_b); else passed++;
            total++; if (busy_a !== 1'b0 || busy_b !== 1'b0) $display("[TB] FAIL reset_busy k=%0d got=%b%b exp=00", k, busy_a, busy_b); else passed++;
            total++; if (done_a !== 1'b0 || done_b !== 1'b0) $display("[TB] FAIL reset_done k=%0d got=%b%b exp=00", k, done_a, done_b); else passed++;
            total++; if (err_a !== 1'b0 || err_b !== 1'b0) $display("[TB] FAIL reset_err k=%0d got=%b%b exp=00", k, err_a, err_b); else passed++;
        end
        // The request present during reset must not have been taken.
        @(posedge clk); #1;
        rstn = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
        #4;
        total++; if (busy_a !== 1'b0 || busy_b !== 1'b0) $display("[TB] FAIL reset_wins_busy got=%b%b exp=00", busy_a, busy_b); else passed++;
        total++; if (ready_a !== 1'b1 || ready_b !== 1'b1) $display("[TB] FAIL reset_wins_ready got=%b%b exp=11", ready_a, ready_b); else passed++;
    endtask

    task automatic test_no_bounce();
        logic [3:0] code;
        logic [2:0] ec;
        int d;
        d = done_index(0);
        for (int run = 0; run < 5; run++) begin
            code = (run < 2) ? 4'd5 : 4'($urandom_range(0, 11));
            for (int k = 0; k <= d; k++) begin
                @(posedge clk); #1;
                valid_a = (k == 0);
                key_code = code;
                rows = (run == 0) ? 4'b0010 : (run == 1) ? 4'b0001 : 4'($urandom_range(0, 15));
                #4;
                ec = exp_cols(k, 0, code, rows);
                total++; if (cols_a !== ec) $display("[TB] FAIL nobounce_cols run=%0d key=%0d k=%0d rows=%b got=%b exp=%b", run, code, k, rows, cols_a, ec); else passed++;
                total++; if (ready_a !== (k == 0 || k == d)) $display("[TB] FAIL nobounce_ready run=%0d k=%0d got=%b", run, k, ready_a); else passed++;
                total++; if (busy_a !== (k > 0 && k < d)) $display("[TB] FAIL nobounce_busy run=%0d k=%0d got=%b", run, k, busy_a); else passed++;
                total++; if (done_a !== (k == d)) $display("[TB] FAIL nobounce_done run=%0d k=%0d got=%b", run, k, done_a); else passed++;
                total++; if (err_a !== 1'b0) $display("[TB] FAIL nobounce_err run=%0d k=%0d got=%b exp=0", run, k, err_a); else passed++;
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] code;
        logic [2:0] ec;
        int d;
        int idle;
        d = done_index(BB);
        for (int run = 0; run < 5; run++) begin
            code = (run == 0) ? 4'd11 : 4'($urandom_range(0, 11));
            for (int k = 0; k <= d; k++) begin
                @(posedge clk); #1;
                valid_b = (k == 0);
                key_code = code;
                rows = (run == 0) ? 4'b1000 : 4'($urandom_range(0, 15));
                #4;
                ec = exp_cols(k, BB, code, rows);
                total++; if (cols_b !== ec) $display("[TB] FAIL bounce_cols run=%0d key=%0d k=%0d rows=%b got=%b exp=%b", run, code, k, rows, cols_b, ec); else passed++;
                total++; if (ready_b !== (k == 0 || k == d)) $display("[TB] FAIL bounce_ready run=%0d k=%0d got=%b", run, k, ready_b); else passed++;
                total++; if (busy_b !== (k > 0 && k < d)) $display("[TB] FAIL bounce_busy run=%0d k=%0d got=%b", run, k, busy_b); else passed++;
                total++; if (done_b !== (k == d)) $display("[TB] FAIL bounce_done run=%0d k=%0d got=%b", run, k, done_b); else passed++;
            end
            idle = $urandom_range(0, 3);
            for (int i = 0; i < idle; i++) begin
                @(posedge clk); #1;
                valid_b = 1'b0;
                rows = 4'($urandom_range(0, 15));
                #4;
                total++; if (cols_b !== 3'b000 || busy_b !== 1'b0 || done_b !== 1'b0) $display("[TB] FAIL bounce_idle i=%0d got cols=%b busy=%b done=%b exp 000/0/0", i, cols_b, busy_b, done_b); else passed++;
            end
        end
    endtask

    task automatic test_invalid();
        logic [3:0] code;
        for (int run = 0; run < 3; run++) begin
            code = (run == 0) ? 4'd13 : 4'($urandom_range(12, 15));
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                valid_b = (k == 0);
                key_code = code;
                rows = 4'($urandom_range(0, 15));
                #4;
                total++; if (err_b !== (k == 1)) $display("[TB] FAIL invalid_err code=%0d k=%0d got=%b", code, k, err_b); else passed++;
                total++; if (cols_b !== 3'b000) $display("[TB] FAIL invalid_cols code=%0d k=%0d got=%b exp=000", code, k, cols_b); else passed++;
                total++; if (busy_b !== 1'b0 || ready_b !== 1'b1) $display("[TB] FAIL invalid_handshake code=%0d k=%0d got busy=%b ready=%b exp 0/1", code, k, busy_b, ready_b); else passed++;
                total++; if (done_b !== 1'b0) $display("[TB] FAIL invalid_done code=%0d k=%0d got=%b exp=0", code, k, done_b); else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ec;
        int d;
        d = done_index(BB);
        for (int k = 0; k <= d; k++) begin
            @(posedge clk); #1;
            valid_b = 1'b1;
            key_code = (k == 0) ? 4'd3 : 4'd7;
            rows = 4'($urandom_range(0, 15));
            #4;
            ec = exp_cols(k, BB, 4'd3, rows);
            total++; if (cols_b !== ec) $display("[TB] FAIL b2b_first_cols k=%0d rows=%b got=%b exp=%b", k, rows, cols_b, ec); else passed++;
            total++; if (ready_b !== (k == 0 || k == d)) $display("[TB] FAIL b2b_first_ready k=%0d got=%b", k, ready_b); else passed++;
            total++; if (done_b !== (k == d)) $display("[TB] FAIL b2b_first_done k=%0d got=%b", k, done_b); else passed++;
        end
        for (int k = 1; k <= d; k++) begin
            @(posedge clk); #1;
            valid_b = 1'b0;
            key_code = 4'd7;
            rows = 4'($urandom_range(0, 15));
            #4;
            ec = exp_cols(k, BB, 4'd7, rows);
            total++; if (cols_b !== ec) $display("[TB] FAIL b2b_second_cols k=%0d rows=%b got=%b exp=%b", k, rows, cols_b, ec); else passed++;
            total++; if (busy_b !== (k < d)) $display("[TB] FAIL b2b_second_busy k=%0d got=%b", k, busy_b); else passed++;
            total++; if (done_b !== (k == d)) $display("[TB] FAIL b2b_second_done k=%0d got=%b", k, done_b); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] ec;
        int d;
        int r;
        d = done_index(BB);
        r = 1 + BB + 3;
        for (int k = 0; k <= r + 1; k++) begin
            @(posedge clk); #1;
            valid_b = (k == 0);
            key_code = 4'd0;
            rows = 4'b1111;
            rstn = (k != r + 1);
            #4;
            ec = exp_cols(k, BB, 4'd0, rows);
            total++; if (cols_b !== ec) $display("[TB] FAIL midreset_pre_cols k=%0d got=%b exp=%b", k, cols_b, ec); else passed++;
        end
        for (int i = 0; i < d; i++) begin
            @(posedge clk); #1;
            rstn = 1'b1;
            rows = (i == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
            #4;
            total++; if (cols_b !== 3'b000) $display("[TB] FAIL midreset_cols i=%0d got=%b exp=000", i, cols_b); else passed++;
            total++; if (ready_b !== 1'b1 || busy_b !== 1'b0) $display("[TB] FAIL midreset_idle i=%0d got ready=%b busy=%b exp 1/0", i, ready_b, busy_b); else passed++;
            total++; if (done_b !== 1'b0 || err_b !== 1'b0) $display("[TB] FAIL midreset_pulse i=%0d got done=%b err=%b exp 0/0", i, done_b, err_b); else passed++;
        end
        for (int k = 0; k <= d; k++) begin
            @(posedge clk); #1;
            valid_b = (k == 0);
            key_code = 4'd0;
            rows = k[0] ? 4'b0000 : 4'b1111;
            #4;
            ec = exp_cols(k, BB, 4'd0, rows);
            total++; if (cols_b !== ec) $display("[TB] FAIL midreset_post_cols k=%0d rows=%b got=%b exp=%b", k, rows, cols_b, ec); else passed++;
            total++; if (done_b !== (k == d)) $display("[TB] FAIL midreset_post_done k=%0d got=%b", k, done_b); else passed++;
        end
    endtask

    initial begin
        rstn     = 1'b0;
        rows     = 4'b0000;
        key_code = 4'd0;
        valid_a  = 1'b0;
        valid_b  = 1'b0;
        test_reset();
        test_no_bounce();
        test_bounce();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
